mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/mmio_console.sv | 107 ++++++++++
 tb/tb_mmio_console.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - memory-mapped console: cycle counter, status, TX byte FIFO and halt latch
// Snoops the core data-memory request bus; reads answer one cycle later on the rsp_* port.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_FFF0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_do_write,
  input  logic [3:0]  req_do_read,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [7:0]  exit_code,
  output logic        done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycle;
  logic          overflow;

  logic          hit;
  logic [1:0]    sel;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic [31:0]   count32;
  logic [31:0]   status;
  logic [31:0]   rd_value;

  always_comb begin
    hit      = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]);
    sel      = req_addr[3:2];
    empty    = (count == '0);
    full     = (count == CW'(FIFO_DEPTH));
    pop      = !empty && tx_ready;
    push_req = hit && (sel == 2'd2) && req_do_write[0];
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    push     = push_req && (!full || pop);
    count32  = 32'(count);
    status   = {12'd0, halt, overflow, empty, full, count32[15:0]};
    rd_value = 32'd0;
    case (sel)
      2'd0:    rd_value = cycle;
      2'd1:    rd_value = status;
      default: rd_value = 32'd0;
    endcase
  end

  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign done     = halt && empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cycle     <= 32'd0;
      halt      <= 1'b0;
      exit_code <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_addr  <= 32'd0;
      rsp_data  <= 32'd0;
    end else begin
      cycle <= cycle + 32'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      if (hit && (sel == 2'd3) && (req_do_write != 4'd0) && !halt) begin
        halt      <= 1'b1;
        exit_code <= req_data[7:0];
      end
      rsp_valid <= hit && (req_do_read != 4'd0);
      if (hit && (req_do_read != 4'd0)) begin
        rsp_addr <= req_addr;
        rsp_data <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// tb/tb_mmio_console.sv - scoreboard bench for mmio_console against a queue-based reference model
// Model updates on rising edges from driven inputs; the monitor compares on falling edges.
module tb_mmio_console;

  localparam logic [31:0] BASE  = 32'h0002_FFF0;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_do_write = 4'd0;
  logic [3:0]  req_do_read = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [7:0]  exit_code;
  logic        done;

  mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_do_write(req_do_write),
    .req_do_read(req_do_read), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halt(halt), .exit_code(exit_code), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // Reference model state
  byte unsigned mq[$];
  logic [63:0]  rsp_q[$];
  logic [31:0]  m_cycle = 0;
  bit           m_ovf = 0;
  bit           m_halt = 0;
  logic [7:0]   m_exit = 0;

  function automatic logic [31:0] m_status();
    int n;
    n = mq.size();
    return n + ((n == DEPTH) << 16) + ((n == 0) << 17) + (int'(m_ovf) << 18) + (int'(m_halt) << 19);
  endfunction

  initial forever begin
    bit m_hit, m_pop, accept;
    int sel;
    logic [31:0] v;
    @(posedge clk);
    if (reset) begin
      mq.delete(); rsp_q.delete();
      m_cycle = 0; m_ovf = 0; m_halt = 0; m_exit = 0;
    end else begin
      m_hit  = req_valid && ((req_addr / 16) == (BASE / 16));
      sel    = (req_addr % 16) / 4;
      m_pop  = (mq.size() > 0) && tx_ready;
      accept = 0;
      if (m_hit && req_do_read != 0) begin
        v = (sel == 0) ? m_cycle : (sel == 1) ? m_status() : 32'd0;
        rsp_q.push_back({req_addr, v});
      end
      if (m_hit && sel == 2 && req_do_write[0]) begin
        if (mq.size() < DEPTH || m_pop) accept = 1;
        else m_ovf = 1;
      end
      if (m_pop) void'(mq.pop_front());
      if (accept) mq.push_back(req_data[7:0]);
      if (m_hit && sel == 3 && req_do_write != 0 && !m_halt) begin
        m_halt = 1;
        m_exit = req_data[7:0];
      end
      m_cycle = m_cycle + 1;
    end
  end

  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!reset) begin
      chk("rsp_valid", rsp_valid, rsp_q.size() != 0);
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        if (rsp_valid) begin
          chk("rsp_addr", rsp_addr, e[63:32]);
          chk("rsp_data", rsp_data, e[31:0]);
        end
      end
      chk("tx_valid", tx_valid, mq.size() != 0);
      if (mq.size() != 0 && tx_valid) chk("tx_data", tx_data, mq[0]);
      chk("halt", halt, m_halt);
      chk("exit_code", exit_code, m_exit);
      chk("done", done, m_halt && mq.size() == 0);
    end
  end

  task automatic req(input logic [31:0] a, input logic [3:0] we, input logic [3:0] re, input logic [31:0] d);
    req_valid = 1'b1; req_addr = a; req_do_write = we; req_do_read = re; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_do_write = 4'd0; req_do_read = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_exit"}, exit_code, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_addr"}, rsp_addr, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    idle(2);
    #1 reset = 1'b0;
    idle(1);
    do_reset("por");
    req(BASE + 4, 0, 4'hF, 0);
    req(BASE, 0, 4'hF, 0);

    // Two bytes drain back-to-back
    tx_ready = 1'b1;
    req(BASE + 8, 4'h1, 0, 32'h41);
    req(BASE + 8, 4'h1, 0, 32'h42);
    idle(3);

    // CYCLE reads 5 cycles apart, then a miss just below the window
    req(BASE, 0, 4'hF, 0);
    idle(4);
    req(BASE, 0, 4'hF, 0);
    req(32'h0002_FFE0, 0, 4'hF, 0);
    idle(2);

    // Push into a full FIFO with a simultaneous pop
    do_reset("r1");
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) req(BASE + 8, 4'h1, 0, i + 8'h20);
    req(BASE + 4, 0, 4'hF, 0);
    tx_ready = 1'b1;
    req(BASE + 8, 4'h1, 0, 32'h55);
    tx_ready = 1'b0;
    req(BASE + 4, 0, 4'hF, 0);
    tx_ready = 1'b1;
    idle(DEPTH + 2);
    req(BASE + 4, 0, 4'hF, 0);

    // Overflow: 17 writes with no draining
    do_reset("r2");
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) req(BASE + 8, 4'h1, 0, i);
    req(BASE + 4, 0, 4'hF, 0);
    req(BASE + 8, 4'h2, 0, 32'h99);
    tx_ready = 1'b1;
    idle(DEPTH + 2);
    req(BASE + 4, 0, 4'hF, 0);

    // Halt with bytes pending; second HALT write must be ignored
    do_reset("r3");
    tx_ready = 1'b0;
    req(BASE + 8, 4'h1, 0, 32'hA1);
    req(BASE + 8, 4'h1, 0, 32'hA2);
    req(BASE + 12, 4'hF, 0, 32'h03);
    req(BASE + 12, 4'hF, 0, 32'h07);
    idle(2);
    tx_ready = 1'b1;
    idle(4);
    req(BASE + 8, 4'h1, 0, 32'hB0);
    idle(2);

    // Asynchronous reset with bytes queued and halt set
    do_reset("r4");
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(BASE + 8, 4'h1, 0, 32'hC0 + i);
    req(BASE + 13, 4'h1, 0, 32'h5A);
    req(BASE + 4, 0, 4'h1, 0);
    do_reset("r5");
    req(BASE, 0, 4'hF, 0);
    req(BASE + 4, 0, 4'hF, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic [3:0]  we, re;
      if (i % 200 == 0) do_reset("rnd");
      a  = ($urandom_range(0, 7) == 0) ? 32'h0002_FFE0 + $urandom_range(0, 15)
                                       : BASE + $urandom_range(0, 15);
      if (a[3:2] == 2'd3 && $urandom_range(0, 7) != 0) a[3:2] = 2'd2;
      we = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom);
      re = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'd0;
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      else req(a, we, re, $urandom);
    end
    tx_ready = 1'b1;
    idle(DEPTH + 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
